// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset/trap vectors, the squash instruction and the supervisor bit.
// Also used by the hazard unit and the exception logic in decode.
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int unsigned SUPER_BIT = 31;

    // Sequential successor: the supervisor bit is kept, the low 31 bits wrap.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return {pc[SUPER_BIT], pc[SUPER_BIT-1:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage: exception > interrupt > redirect > stall > sequential.
// Also produces the IF/ID squash control and the EPC update.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = cpu_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC = cpu_pkg::EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        irq_req,
    input  logic        exc_req,
    input  logic [31:0] exc_epc,
    output logic [31:0] next_pc,
    output logic [31:0] seq_pc,
    output logic        if_id_squash,
    output logic        epc_load,
    output logic [31:0] epc_next,
    output logic        irq_ok
);

    logic [31:0] aligned_target;

    always_comb begin
        seq_pc         = seq_pc_of(pc);
        aligned_target = {redirect_pc[31:2], 2'b00};
        // Interrupts are masked in supervisor mode and yield to a simultaneous exception.
        irq_ok         = irq_req && !pc[SUPER_BIT] && !exc_req;
        next_pc        = seq_pc;
        epc_load       = 1'b0;
        epc_next       = pc;

        if (exc_req) begin
            next_pc  = EXC_VEC;
            epc_load = 1'b1;
            epc_next = exc_epc;
        end else if (irq_ok) begin
            next_pc  = IRQ_VEC;
            epc_load = 1'b1;
            epc_next = redirect_valid ? aligned_target : pc;
        end else if (redirect_valid) begin
            next_pc = aligned_target;
        end else if (stall) begin
            next_pc = pc;
        end

        if_id_squash = exc_req || irq_ok || redirect_valid || flush;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM address, IF/ID pipeline register and EPC capture.
// Redirects reach imem_addr one cycle later and the target word lands in IF/ID one cycle after that.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] IRQ_VEC  = cpu_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = cpu_pkg::EXC_VEC,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        irq_req,
    input  logic        exc_req,
    input  logic [31:0] exc_epc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] epc,
    output logic        irq_taken
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] seq_pc;
    logic        if_id_squash;
    logic        epc_load;
    logic [31:0] epc_next;
    logic        irq_ok;

    pc_next_sel #(
        .IRQ_VEC(IRQ_VEC),
        .EXC_VEC(EXC_VEC)
    ) u_pc_next_sel (
        .pc            (pc),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .irq_req       (irq_req),
        .exc_req       (exc_req),
        .exc_epc       (exc_epc),
        .next_pc       (next_pc),
        .seq_pc        (seq_pc),
        .if_id_squash  (if_id_squash),
        .epc_load      (epc_load),
        .epc_next      (epc_next),
        .irq_ok        (irq_ok)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'h0000_0000;
            if_id_valid    <= 1'b0;
            epc            <= 32'h0000_0000;
            irq_taken      <= 1'b0;
        end else begin
            pc        <= next_pc;
            irq_taken <= irq_ok;
            if (epc_load) begin
                epc <= epc_next;
            end
            // A squash wins over stall so a flushed slot never re-issues the held word.
            if (if_id_squash) begin
                if_id_instr    <= NOP_WORD;
                if_id_pc_plus4 <= seq_pc;
                if_id_valid    <= 1'b0;
            end else if (!stall) begin
                if_id_instr    <= imem_data;
                if_id_pc_plus4 <= seq_pc;
                if_id_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a combinational ROM model.
// Each record holds the inputs for one clock edge and the state expected right after it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irq_req;
    logic        exc_req;
    logic [31:0] exc_epc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        irq_taken;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        fl;
        logic        rv;
        logic [31:0] rpc;
        logic        irq;
        logic        exc;
        logic [31:0] eepc;
        logic [31:0] x_pc;
        logic [31:0] x_instr;
        logic [31:0] x_pp4;
        logic        x_valid;
        logic [31:0] x_epc;
        logic        x_irq;
    } vec_t;

    vec_t vecs[$];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .irq_req       (irq_req),
        .exc_req       (exc_req),
        .exc_epc       (exc_epc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .epc           (epc),
        .irq_taken     (irq_taken)
    );

    // ROM model: the word index (addr[17:2]) tagged with C0DE in the upper half.
    assign imem_data = {16'hC0DE, imem_addr[17:2]};

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic st, input logic fl, input logic rv,
                                input logic [31:0] rpc, input logic irq, input logic exc,
                                input logic [31:0] eepc, input logic [31:0] x_pc,
                                input logic [31:0] x_instr, input logic [31:0] x_pp4,
                                input logic x_valid, input logic [31:0] x_epc, input logic x_irq);
        vec_t v;
        v.rst = rst; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc; v.irq = irq;
        v.exc = exc; v.eepc = eepc; v.x_pc = x_pc; v.x_instr = x_instr; v.x_pp4 = x_pp4;
        v.x_valid = x_valid; v.x_epc = x_epc; v.x_irq = x_irq;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one vector's inputs at the falling edge, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = v.rst; stall = v.st; flush = v.fl; redirect_valid = v.rv;
        redirect_pc = v.rpc; irq_req = v.irq; exc_req = v.exc; exc_epc = v.eepc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input vec_t v);
        checkOutput({tag, ".imem_addr"}, imem_addr, v.x_pc);
        checkOutput({tag, ".if_id_instr"}, if_id_instr, v.x_instr);
        checkOutput({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, v.x_pp4);
        checkOutput({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, v.x_valid});
        checkOutput({tag, ".epc"}, epc, v.x_epc);
        checkOutput({tag, ".irq_taken"}, {31'd0, irq_taken}, {31'd0, v.x_irq});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; irq_req = 1'b0; exc_req = 1'b0; exc_epc = '0;

        //              rst st fl rv rpc            irq exc eepc   pc             instr          pp4            v  epc            it
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h8000_0000, 32'h0,         32'h0,         0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h8000_0004, 32'hC0DE_0000, 32'h8000_0004, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h8000_0008, 32'hC0DE_0001, 32'h8000_0008, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h8000_000C, 32'hC0DE_0002, 32'h8000_000C, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0012, 0, 0, 32'h0, 32'h0000_0010, 32'h0,         32'h8000_0010, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_00B6, 0, 0, 32'h0, 32'h0000_00B4, 32'h0,         32'h0000_0014, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_00B8, 32'hC0DE_002D, 32'h0000_00B8, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_001C, 0, 0, 32'h0, 32'h0000_001C, 32'h0,         32'h0000_00BC, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0020, 32'hC0DE_0007, 32'h0000_0020, 1, 32'h0,         0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0020, 32'hC0DE_0007, 32'h0000_0020, 1, 32'h0,         0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0020, 32'hC0DE_0007, 32'h0000_0020, 1, 32'h0,         0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0020, 32'hC0DE_0007, 32'h0000_0020, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0024, 32'hC0DE_0008, 32'h0000_0024, 1, 32'h0,         0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0028, 32'h0,         32'h0000_0028, 0, 32'h0,         0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0028, 32'h0,         32'h0000_002C, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0040, 0, 0, 32'h0, 32'h0000_0040, 32'h0,         32'h0000_002C, 0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h0, 32'h8000_0004, 32'h0,         32'h0000_0044, 0, 32'h0000_0040, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 0, 32'h0, 32'h8000_0008, 32'hC0DE_0001, 32'h8000_0008, 1, 32'h0000_0040, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h0, 32'h8000_0008, 32'hC0DE_0001, 32'h8000_0008, 1, 32'h0000_0040, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0100, 1, 0, 32'h0, 32'h0000_0100, 32'h0,         32'h8000_000C, 0, 32'h0000_0040, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0104, 32'hC0DE_0040, 32'h0000_0104, 1, 32'h0000_0040, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h0000_0100, 1, 0, 32'h0, 32'h8000_0004, 32'h0,         32'h0000_0108, 0, 32'h0000_0100, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0000_0050, 0, 0, 32'h0, 32'h0000_0050, 32'h0,         32'h8000_0008, 0, 32'h0000_0100, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h0000_0054, 32'h8000_0008, 32'h0, 32'h0000_0054, 0, 32'h0000_0054, 0));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0000_0060, 0, 0, 32'h0, 32'h8000_0000, 32'h0,         32'h0,         0, 32'h0,         0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0, 32'h8000_0004, 32'hC0DE_0000, 32'h8000_0004, 1, 32'h0,         0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkState($sformatf("vec%0d", i), vecs[i]);
        end

        // User-mode wrap: 7FFF_FFFC advances to 0000_0000 with the supervisor bit still clear.
        applyStimulus(mk(0, 0, 0, 1, 32'h7FFF_FFFE, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        checkOutput("wrap_user.redirect_aligned", imem_addr, 32'h7FFF_FFFC);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        checkOutput("wrap_user.pc", imem_addr, 32'h0000_0000);
        checkOutput("wrap_user.instr", if_id_instr, 32'hC0DE_FFFF);
        checkOutput("wrap_user.pp4", if_id_pc_plus4, 32'h0000_0000);

        // Supervisor wrap: FFFF_FFFC advances to 8000_0000.
        applyStimulus(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        checkOutput("wrap_super.pc", imem_addr, 32'h8000_0000);
        checkOutput("wrap_super.pp4", if_id_pc_plus4, 32'h8000_0000);
        checkOutput("wrap_super.valid", {31'd0, if_id_valid}, 32'd1);

        // Interrupt pulse lasts exactly one cycle even with irq_req held at a user PC.
        applyStimulus(mk(0, 0, 0, 1, 32'h0000_0200, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        checkOutput("irq_pulse.taken", {31'd0, irq_taken}, 32'd1);
        checkOutput("irq_pulse.epc", epc, 32'h0000_0200);
        applyStimulus(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0));
        checkOutput("irq_pulse.drop", {31'd0, irq_taken}, 32'd0);
        checkOutput("irq_pulse.epc_hold", epc, 32'h0000_0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
